// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
package pipe_hazard_ctrl_pkg;

    // Sequencer state encoding.
    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_FAULT    = 2'd3
    } state_t;

    // Register $zero never carries a real dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // True when the instruction in ID reads the destination of the load in EX.
    function automatic logic load_use_hit(
        input logic       mem_read,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt
    );
        return mem_read && (ex_rt != REG_ZERO) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    // Count up on inc until all-ones, then hold.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline registers. Control outputs
// are decoded combinationally from state and current inputs so they act on
// the pipeline registers at the same clock edge.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int INIT_CYCLES = 4,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_RegisterRt,
    input  logic [4:0]       IF_ID_RegisterRs,
    input  logic [4:0]       IF_ID_RegisterRt,
    input  logic             BranchTaken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             Pipe_Hold,
    output logic             fault,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t     state_reg;
    logic [7:0] wait_cnt_reg;
    logic       fault_reg;

    logic mem_wait;
    logic load_use;
    logic active;
    logic stall_inc;
    logic flush_inc;

    assign mem_wait = dmem_req && !dmem_ready;
    assign load_use = load_use_hit(ID_EX_MemRead, ID_EX_RegisterRt,
                                   IF_ID_RegisterRs, IF_ID_RegisterRt);
    assign active   = (state_reg == ST_RUN) || (state_reg == ST_MEM_WAIT);

    // Memory wait outranks branch, branch outranks load-use; at most one
    // counter event per cycle, none outside RUN/MEM_WAIT.
    assign stall_inc = active && (mem_wait || (!BranchTaken && load_use));
    assign flush_inc = active && !mem_wait && BranchTaken;

    // Decode pipeline-register controls from state and current hazards.
    always_comb begin
        PCWrite     = 1'b1;
        IF_ID_Write = 1'b1;
        IF_ID_Flush = 1'b0;
        ID_EX_Flush = 1'b0;
        Pipe_Hold   = 1'b0;
        case (state_reg)
            ST_INIT: begin
                PCWrite     = 1'b0;
                IF_ID_Flush = 1'b1;
                ID_EX_Flush = 1'b1;
            end
            ST_RUN, ST_MEM_WAIT: begin
                if (mem_wait) begin
                    PCWrite     = 1'b0;
                    IF_ID_Write = 1'b0;
                    Pipe_Hold   = 1'b1;
                end else if (BranchTaken) begin
                    IF_ID_Flush = 1'b1;
                    ID_EX_Flush = 1'b1;
                end else if (load_use) begin
                    PCWrite     = 1'b0;
                    IF_ID_Write = 1'b0;
                    ID_EX_Flush = 1'b1;
                end
            end
            ST_FAULT: begin
                PCWrite     = 1'b0;
                IF_ID_Write = 1'b0;
                ID_EX_Flush = 1'b1;
                Pipe_Hold   = 1'b1;
            end
            default: ;
        endcase
    end

    // Sequencer: purge countdown, memory-wait timeout, sticky fault.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= ST_INIT;
            wait_cnt_reg <= 8'(INIT_CYCLES - 1);
            fault_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    if (wait_cnt_reg == 8'd0) begin
                        state_reg <= ST_RUN;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 8'd1;
                    end
                end
                ST_RUN, ST_MEM_WAIT: begin
                    if (mem_wait) begin
                        if (state_reg == ST_RUN) begin
                            state_reg    <= ST_MEM_WAIT;
                            wait_cnt_reg <= 8'd1;
                        end else if (wait_cnt_reg == 8'(MEM_TIMEOUT - 1)) begin
                            state_reg <= ST_FAULT;
                            fault_reg <= 1'b1;
                        end else begin
                            wait_cnt_reg <= wait_cnt_reg + 8'd1;
                        end
                    end else begin
                        // Ready, or request withdrawn: the access is over.
                        state_reg <= ST_RUN;
                    end
                end
                ST_FAULT: ;
                default: state_reg <= ST_INIT;
            endcase
        end
    end

    assign fault = fault_reg;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (INIT_CYCLES=4, MEM_TIMEOUT=8, CNT_W=4).
// Control outputs are packed as {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Pipe_Hold}.
module tb_pipe_hazard_ctrl;

    localparam int INIT_CYCLES = 4;
    localparam int MEM_TIMEOUT = 8;
    localparam int CNT_W       = 4;

    localparam logic [4:0] CTL_INIT  = 5'b01110;
    localparam logic [4:0] CTL_RUN   = 5'b11000;
    localparam logic [4:0] CTL_LDUSE = 5'b00010;
    localparam logic [4:0] CTL_BR    = 5'b11110;
    localparam logic [4:0] CTL_MEMW  = 5'b00001;
    localparam logic [4:0] CTL_FAULT = 5'b00011;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             ID_EX_MemRead = 1'b0;
    logic [4:0]       ID_EX_RegisterRt = 5'd0;
    logic [4:0]       IF_ID_RegisterRs = 5'd0;
    logic [4:0]       IF_ID_RegisterRt = 5'd0;
    logic             BranchTaken = 1'b0;
    logic             dmem_req = 1'b0;
    logic             dmem_ready = 1'b0;
    logic             PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Pipe_Hold, fault;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [4:0]       ctl;

    int checks   = 0;
    int failures = 0;

    assign ctl = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Pipe_Hold};

    always #5 CLK = ~CLK;

    pipe_hazard_ctrl #(
        .INIT_CYCLES (INIT_CYCLES),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .CLK              (CLK),
        .RST              (RST),
        .ID_EX_MemRead    (ID_EX_MemRead),
        .ID_EX_RegisterRt (ID_EX_RegisterRt),
        .IF_ID_RegisterRs (IF_ID_RegisterRs),
        .IF_ID_RegisterRt (IF_ID_RegisterRt),
        .BranchTaken      (BranchTaken),
        .dmem_req         (dmem_req),
        .dmem_ready       (dmem_ready),
        .PCWrite          (PCWrite),
        .IF_ID_Write      (IF_ID_Write),
        .IF_ID_Flush      (IF_ID_Flush),
        .ID_EX_Flush      (ID_EX_Flush),
        .Pipe_Hold        (Pipe_Hold),
        .fault            (fault),
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt)
    );

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        ID_EX_MemRead    = 1'b0;
        ID_EX_RegisterRt = 5'd0;
        IF_ID_RegisterRs = 5'd0;
        IF_ID_RegisterRt = 5'd0;
        BranchTaken      = 1'b0;
        dmem_req         = 1'b0;
        dmem_ready       = 1'b0;
    endtask

    // Reset for two cycles, release, and let the 4-cycle purge finish.
    task automatic reset_to_run();
        idle_inputs();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        repeat (INIT_CYCLES) tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        RST = 1'b1;
        tick();
        #1;
        checks++;
        if (ctl !== CTL_INIT || fault !== 1'b0 || stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
            $display("FAIL reset_hold ctl=%b fault=%b stall=%0d flush=%0d required ctl=%b fault=0 cnt=0",
                     ctl, fault, stall_cnt, flush_cnt, CTL_INIT);
            failures++;
        end
        tick();
        RST = 1'b0;
        for (int i = 0; i < INIT_CYCLES; i++) begin
            #1;
            checks++;
            if (ctl !== CTL_INIT) begin
                $display("FAIL purge_cycle%0d ctl=%b required %b", i, ctl, CTL_INIT);
                failures++;
            end
            tick();
        end
        #1;
        checks++;
        if (ctl !== CTL_RUN) begin
            $display("FAIL purge_exit ctl=%b required %b", ctl, CTL_RUN);
            failures++;
        end
        $display("test_reset done ctl=%b", ctl);
    endtask

    task automatic test_load_use();
        reset_to_run();
        ID_EX_MemRead = 1'b1; ID_EX_RegisterRt = 5'd5; IF_ID_RegisterRs = 5'd5;
        #1;
        checks++;
        if (ctl !== CTL_LDUSE) begin
            $display("FAIL load_use_rs ctl=%b required %b", ctl, CTL_LDUSE);
            failures++;
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (stall_cnt !== 4'd1 || ctl !== CTL_RUN) begin
            $display("FAIL load_use_bubble stall=%0d ctl=%b required stall=1 ctl=%b", stall_cnt, ctl, CTL_RUN);
            failures++;
        end
        // Destination $zero: never a hazard.
        ID_EX_MemRead = 1'b1; ID_EX_RegisterRt = 5'd0; IF_ID_RegisterRs = 5'd0; IF_ID_RegisterRt = 5'd0;
        #1;
        checks++;
        if (ctl !== CTL_RUN) begin
            $display("FAIL load_use_zero ctl=%b required %b", ctl, CTL_RUN);
            failures++;
        end
        tick();
        // Match through the Rt source instead.
        ID_EX_MemRead = 1'b1; ID_EX_RegisterRt = 5'd7; IF_ID_RegisterRs = 5'd3; IF_ID_RegisterRt = 5'd7;
        #1;
        checks++;
        if (ctl !== CTL_LDUSE) begin
            $display("FAIL load_use_rt ctl=%b required %b", ctl, CTL_LDUSE);
            failures++;
        end
        tick();
        // Register match but no load in EX.
        ID_EX_MemRead = 1'b0;
        #1;
        checks++;
        if (ctl !== CTL_RUN || stall_cnt !== 4'd2) begin
            $display("FAIL no_memread ctl=%b stall=%0d required ctl=%b stall=2", ctl, stall_cnt, CTL_RUN);
            failures++;
        end
        tick();
        idle_inputs();
        $display("test_load_use done stall=%0d", stall_cnt);
    endtask

    task automatic test_branch();
        reset_to_run();
        BranchTaken = 1'b1;
        ID_EX_MemRead = 1'b1; ID_EX_RegisterRt = 5'd9; IF_ID_RegisterRs = 5'd9;
        #1;
        checks++;
        if (ctl !== CTL_BR) begin
            $display("FAIL branch_over_load_use ctl=%b required %b", ctl, CTL_BR);
            failures++;
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
            $display("FAIL branch_counts flush=%0d stall=%0d required flush=1 stall=0", flush_cnt, stall_cnt);
            failures++;
        end
        $display("test_branch done flush=%0d", flush_cnt);
    endtask

    task automatic test_mem_wait();
        reset_to_run();
        dmem_req = 1'b1; dmem_ready = 1'b0; BranchTaken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ctl !== CTL_MEMW) begin
                $display("FAIL mem_wait_cycle%0d ctl=%b required %b", i, ctl, CTL_MEMW);
                failures++;
            end
            tick();
        end
        dmem_ready = 1'b1;
        #1;
        checks++;
        if (ctl !== CTL_BR) begin
            $display("FAIL mem_ready_branch ctl=%b required %b", ctl, CTL_BR);
            failures++;
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (stall_cnt !== 4'd3 || flush_cnt !== 4'd1 || ctl !== CTL_RUN) begin
            $display("FAIL mem_wait_after stall=%0d flush=%0d ctl=%b required stall=3 flush=1 ctl=%b",
                     stall_cnt, flush_cnt, ctl, CTL_RUN);
            failures++;
        end
        // Request withdrawn mid-wait returns to normal operation.
        dmem_req = 1'b1;
        tick();
        dmem_req = 1'b0;
        #1;
        checks++;
        if (ctl !== CTL_RUN) begin
            $display("FAIL mem_req_drop ctl=%b required %b", ctl, CTL_RUN);
            failures++;
        end
        tick();
        $display("test_mem_wait done stall=%0d", stall_cnt);
    endtask

    task automatic test_timeout();
        reset_to_run();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            #1;
            checks++;
            if (ctl !== CTL_MEMW || fault !== 1'b0) begin
                $display("FAIL timeout_wait%0d ctl=%b fault=%b required ctl=%b fault=0", i, ctl, fault, CTL_MEMW);
                failures++;
            end
            tick();
        end
        #1;
        checks++;
        if (fault !== 1'b1 || ctl !== CTL_FAULT || stall_cnt !== 4'd8) begin
            $display("FAIL timeout_fault fault=%b ctl=%b stall=%0d required fault=1 ctl=%b stall=8",
                     fault, ctl, stall_cnt, CTL_FAULT);
            failures++;
        end
        // Inputs that would otherwise act are ignored; counters freeze.
        dmem_ready = 1'b1; BranchTaken = 1'b1;
        ID_EX_MemRead = 1'b1; ID_EX_RegisterRt = 5'd4; IF_ID_RegisterRs = 5'd4;
        repeat (3) tick();
        #1;
        checks++;
        if (fault !== 1'b1 || ctl !== CTL_FAULT || stall_cnt !== 4'd8 || flush_cnt !== 4'd0) begin
            $display("FAIL fault_frozen fault=%b ctl=%b stall=%0d flush=%0d required fault=1 ctl=%b stall=8 flush=0",
                     fault, ctl, stall_cnt, flush_cnt, CTL_FAULT);
            failures++;
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        idle_inputs();
        #1;
        checks++;
        if (fault !== 1'b0 || ctl !== CTL_INIT || stall_cnt !== 4'd0) begin
            $display("FAIL fault_reset fault=%b ctl=%b stall=%0d required fault=0 ctl=%b stall=0",
                     fault, ctl, stall_cnt, CTL_INIT);
            failures++;
        end
        repeat (INIT_CYCLES) tick();
        $display("test_timeout done fault=%b", fault);
    endtask

    task automatic test_saturation();
        reset_to_run();
        ID_EX_MemRead = 1'b1; ID_EX_RegisterRt = 5'd12; IF_ID_RegisterRt = 5'd12;
        repeat (14) tick();
        #1;
        checks++;
        if (stall_cnt !== 4'd14) begin
            $display("FAIL sat_before stall=%0d required 14", stall_cnt);
            failures++;
        end
        repeat (6) tick();
        #1;
        checks++;
        if (stall_cnt !== 4'hF) begin
            $display("FAIL sat_hold stall=%0d required 15", stall_cnt);
            failures++;
        end
        idle_inputs();
        tick();
        $display("test_saturation done stall=%0d", stall_cnt);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generates PC write-enable, IF/ID write-enable and flush, ID/EX flush, and a back-end hold for EX/MEM and MEM/WB. The team adds the hold enable and the IF/ID flush input to those registers.
- Covers post-reset pipeline purge, load-use stalls, taken-branch flushes, and multi-cycle data-memory waits with timeout.
- Keeps saturating stall/flush event counters.

Parameters:
INIT_CYCLES, 4, cycles of purge after reset (1..15)
MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before fault (2..255)
CNT_W, 16, width of event counters

Ports:
CLK  in  1  clock, all state on posedge
RST  in  1  synchronous active-high reset
ID_EX_MemRead  in  1  load currently in EX
ID_EX_RegisterRt  in  5  load destination
IF_ID_RegisterRs  in  5  source 1 of instruction in ID
IF_ID_RegisterRt  in  5  source 2 of instruction in ID
BranchTaken  in  1  branch/jump resolved taken in EX
dmem_req  in  1  EX/MEM stage issuing a load or store
dmem_ready  in  1  data memory completes access this cycle
PCWrite  out  1  PC load enable
IF_ID_Write  out  1  IF/ID load enable
IF_ID_Flush  out  1  IF/ID loads zero (NOP)
ID_EX_Flush  out  1  ID/EX loads bubble
Pipe_Hold  out  1  EX/MEM and MEM/WB hold value
fault  out  1  sticky memory-timeout fault
stall_cnt  out  CNT_W  load-use plus memory-wait stall cycles, saturating
flush_cnt  out  CNT_W  taken-branch flush events, saturating

Behaviour:
- Clocking and reset:
  - Single clock.
  - Reset is synchronous and active-high on RST. It is sampled at posedge CLK and has priority over all inputs.
- FSM states:
  - INIT: entered on reset; wait_cnt=INIT_CYCLES-1.
  - RUN
  - MEM_WAIT
  - FAULT
- Registered state: state, wait_cnt (8b), fault, stall_cnt, flush_cnt.
  - Reset values: state=INIT, fault=0, both counters=0.
- Outputs are a combinational decode of state and current inputs. Their effect lands in the pipeline registers at the same posedge (zero-cycle latency).
- Default outputs: PCWrite=1, IF_ID_Write=1, all flushes=0, Pipe_Hold=0.
- INIT:
  - Outputs: PCWrite=0, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Flush=1, Pipe_Hold=0. All other inputs are ignored.
  - wait_cnt decrements each cycle; at 0, go to RUN.
  - Exactly INIT_CYCLES purge cycles follow reset release.
  - Because reset values are held while RST=1, outputs equal the INIT values during reset.
- RUN and MEM_WAIT evaluate by priority:
  1. Memory wait (dmem_req & !dmem_ready):
     - PCWrite=0, IF_ID_Write=0, ID_EX_Flush=0, Pipe_Hold=1. BranchTaken and load-use are ignored this cycle.
     - stall_cnt+1.
     - From RUN: go to MEM_WAIT, wait_cnt=1.
     - In MEM_WAIT: if wait_cnt==MEM_TIMEOUT-1, go to FAULT and set fault=1; else wait_cnt+1.
  2. BranchTaken:
     - PCWrite=1, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Flush=1.
     - flush_cnt+1. State goes to RUN.
  3. Load-use (ID_EX_MemRead & ID_EX_RegisterRt!=0 & (ID_EX_RegisterRt==IF_ID_RegisterRs | ID_EX_RegisterRt==IF_ID_RegisterRt)):
     - PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1.
     - stall_cnt+1. State goes to RUN.
     - Produces one bubble: the next cycle sees ID_EX_MemRead=0.
  4. Otherwise: defaults; state goes to RUN.
- dmem_ready is the exit condition of MEM_WAIT. In the cycle dmem_ready=1, normal priority 2..4 evaluation applies and the state returns to RUN.
- dmem_req=0 while in MEM_WAIT is treated as complete: return to RUN.
- FAULT:
  - Outputs: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1, Pipe_Hold=1.
  - Only RST leaves FAULT.
  - fault stays 1 until reset. Counters freeze.
- Counters saturate at all-ones and never wrap.
- Counters increment at most once per cycle; memory-wait and load-use cannot coincide.
- Reset mid-MEM_WAIT or mid-FAULT: the next cycle is INIT with fault=0 and counters=0.

Decomposition:
- Shared package: state encoding (INIT=2'd0, RUN=2'd1, MEM_WAIT=2'd2, FAULT=2'd3), REG_ZERO=5'd0.
- One sub-module: sat_counter (width parameter, inc, RST). It is instantiated twice, for stall_cnt and flush_cnt.

Test Plan:
1. RST high 2 cycles then low, INIT_CYCLES=4 -> flushes=1 and PCWrite=0 for exactly 4 cycles, then PCWrite=1 and state RUN.
2. ID_EX_MemRead=1, ID_EX_RegisterRt=5, IF_ID_RegisterRs=5 for 1 cycle -> PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1 that cycle, stall_cnt=1. The same stimulus with Rt=0 gives no stall.
3. BranchTaken=1 together with a load-use match -> IF_ID_Flush=1, ID_EX_Flush=1, PCWrite=1, flush_cnt=1, stall_cnt unchanged.
4. dmem_req=1, dmem_ready=0 for 3 cycles then 1 -> Pipe_Hold=1 for 3 cycles, 0 on the ready cycle, stall_cnt=3, state RUN afterwards. BranchTaken held throughout is applied only on the ready cycle.
5. dmem_req=1, dmem_ready=0 forever, MEM_TIMEOUT=8 -> fault=1 after 8 wait cycles, outputs frozen. A RST pulse clears fault and re-enters INIT.
6. Force stall_cnt near all-ones (CNT_W=4) with 20 stall cycles -> stall_cnt holds at 4'hF.
